sipo_deserializer: RTL and testbench

- Parametrised serial-in/parallel-out deserializer; successor to the fixed 4-bit SIPO shift register.
- Collects WIDTH serial bits qualified by si_valid and presents each completed word on a held parallel output with a valid/ack handshake.
- Selectable bit order; overflow detection; optional frame parity check.
- Sits between the serial channel and the Hamming decoder input (WIDTH = codeword length, e.g. 7).

---
 rtl/sipo_deserializer.sv | 117 +++++++++++
 tb/tb_sipo_deserializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with valid/ack output handshake and overflow flag.
// Define SIPO_PARITY_CHK_EN to append an even-parity bit to each frame and check it.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       si,
    input  logic                       si_valid,
    input  logic                       clear,
    output logic [WIDTH-1:0]           po,
    output logic                       po_valid,
    input  logic                       po_ack,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overflow,
    output logic                       parity_err
);

    localparam int CW = $clog2(WIDTH+1);
`ifdef SIPO_PARITY_CHK_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(FL - 1);

    logic [WIDTH-1:0] sr, sr_shift, sr_nxt, po_nxt, word;
    logic [CW-1:0]    cnt_nxt;
    logic             data_bit, pv_nxt, ovf_nxt;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign sr_shift = {si, sr[WIDTH-1:1]};
        end else begin : g_msb
            assign sr_shift = {sr[WIDTH-2:0], si};
        end
    endgenerate

`ifdef SIPO_PARITY_CHK_EN
    // The trailing parity bit never enters sr, so sr already holds the full word.
    logic perr_nxt;
    assign data_bit = (bit_cnt != LAST);
    assign word     = sr;
`else
    assign data_bit = 1'b1;
    assign word     = sr_shift;
`endif

    always_comb begin
        sr_nxt  = sr;
        cnt_nxt = bit_cnt;
        po_nxt  = po;
        pv_nxt  = po_valid;
        ovf_nxt = overflow;
`ifdef SIPO_PARITY_CHK_EN
        perr_nxt = parity_err;
`endif
        if (clear) begin
            sr_nxt  = '0;
            cnt_nxt = '0;
            pv_nxt  = 1'b0;
            ovf_nxt = 1'b0;
`ifdef SIPO_PARITY_CHK_EN
            perr_nxt = 1'b0;
`endif
        end else begin
            if (po_valid && po_ack)
                pv_nxt = 1'b0;
            if (si_valid) begin
                if (data_bit)
                    sr_nxt = sr_shift;
                if (bit_cnt == LAST) begin
                    // Completion wins over a same-edge ack; overflow only if nobody took the old word.
                    cnt_nxt = '0;
                    po_nxt  = word;
                    pv_nxt  = 1'b1;
                    if (po_valid && !po_ack)
                        ovf_nxt = 1'b1;
`ifdef SIPO_PARITY_CHK_EN
                    perr_nxt = (^sr) ^ si;
`endif
                end else begin
                    cnt_nxt = bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            po       <= '0;
            po_valid <= 1'b0;
            bit_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            sr       <= sr_nxt;
            po       <= po_nxt;
            po_valid <= pv_nxt;
            bit_cnt  <= cnt_nxt;
            overflow <= ovf_nxt;
        end
    end

`ifdef SIPO_PARITY_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_err <= 1'b0;
        else
            parity_err <= perr_nxt;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first and LSB-first instances share stimulus.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst_n, si, si_valid, clear, po_ack;
    logic [3:0] po_m, po_l;
    logic       pv_m, pv_l, ovf_m, ovf_l, perr_m, perr_l;
    logic [2:0] cnt_m, cnt_l;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .si(si), .si_valid(si_valid), .clear(clear),
        .po(po_m), .po_valid(pv_m), .po_ack(po_ack), .bit_cnt(cnt_m),
        .overflow(ovf_m), .parity_err(perr_m)
    );

    sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .si(si), .si_valid(si_valid), .clear(clear),
        .po(po_l), .po_valid(pv_l), .po_ack(po_ack), .bit_cnt(cnt_l),
        .overflow(ovf_l), .parity_err(perr_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        si       = b;
        si_valid = 1'b1;
        @(posedge clk);
        #1;
        si_valid = 1'b0;
    endtask

    task automatic idle(input logic b);
        si       = b;
        si_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Sends w[3] first; appends the even-parity bit when the parity frame is built in.
    task automatic send_word(input logic [3:0] w, input bit ack_last);
        for (int i = 3; i >= 0; i--) begin
`ifndef SIPO_PARITY_CHK_EN
            if (i == 0) po_ack = ack_last;
`endif
            send_bit(w[i]);
        end
`ifdef SIPO_PARITY_CHK_EN
        po_ack = ack_last;
        send_bit(^w);
`endif
        po_ack = 1'b0;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        si       = 1'b1;
        si_valid = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        si_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; si = 1'b0; si_valid = 1'b0; clear = 1'b0; po_ack = 1'b0;
        #12;
        chk("rst_po", po_m, 4'h0);
        chk("rst_pv", pv_m, 1'b0);
        chk("rst_cnt", cnt_m, 3'd0);
        chk("rst_ovf", ovf_m, 1'b0);
        chk("rst_perr", perr_m, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1011 on consecutive cycles
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        chk("cnt3", cnt_m, 3'd3);
        chk("pv_early", pv_m, 1'b0);
        send_bit(1'b1);
`ifdef SIPO_PARITY_CHK_EN
        chk("cnt4_par", cnt_m, 3'd4);
        chk("pv_before_par", pv_m, 1'b0);
        send_bit(1'b1);
`endif
        chk("msb_po", po_m, 4'b1011);
        chk("msb_pv", pv_m, 1'b1);
        chk("msb_cnt", cnt_m, 3'd0);
        chk("lsb_po", po_l, 4'b1101);
        chk("lsb_pv", pv_l, 1'b1);

        // Acknowledge, then a stray ack with nothing pending
        po_ack = 1'b1;
        idle(1'b0);
        chk("ack_pv", pv_m, 1'b0);
        idle(1'b0);
        po_ack = 1'b0;
        chk("ack_idle_pv", pv_m, 1'b0);
        chk("ack_po_hold", po_m, 4'b1011);

        // Gapped frame 1,x,1,x,0,x,0
        send_bit(1'b1); idle(1'b0);
        chk("gap_cnt1", cnt_m, 3'd1);
        send_bit(1'b1); idle(1'b1);
        chk("gap_cnt2", cnt_m, 3'd2);
        send_bit(1'b0); idle(1'b1);
        chk("gap_cnt3", cnt_m, 3'd3);
        send_bit(1'b0);
`ifdef SIPO_PARITY_CHK_EN
        idle(1'b1);
        send_bit(1'b0);
`endif
        chk("gap_po", po_m, 4'b1100);
        chk("gap_po_lsb", po_l, 4'b0011);
        chk("gap_pv", pv_m, 1'b1);

        po_ack = 1'b1;
        idle(1'b0);
        po_ack = 1'b0;

        // Back-to-back frames, no ack: overwrite flags overflow
        send_word(4'b1011, 1'b0);
        chk("b2b_ovf0", ovf_m, 1'b0);
        send_word(4'b0110, 1'b0);
        chk("b2b_po", po_m, 4'b0110);
        chk("b2b_pv", pv_m, 1'b1);
        chk("b2b_ovf", ovf_m, 1'b1);
        chk("b2b_ovf_lsb", ovf_l, 1'b1);

        do_clear();
        chk("clr_ovf", ovf_m, 1'b0);
        chk("clr_pv", pv_m, 1'b0);
        chk("clr_po_hold", po_m, 4'b0110);

        // Same pair with ack on the second completion edge
        send_word(4'b1011, 1'b0);
        send_word(4'b0110, 1'b1);
        chk("ack_b2b_ovf", ovf_m, 1'b0);
        chk("ack_b2b_pv", pv_m, 1'b1);
        chk("ack_b2b_po", po_m, 4'b0110);

        // Clear after two bits abandons the partial word
        send_bit(1'b1); send_bit(1'b1);
        chk("pre_clr_cnt", cnt_m, 3'd2);
        do_clear();
        chk("clr_cnt", cnt_m, 3'd0);
        chk("clr_pv2", pv_m, 1'b0);
        send_word(4'b0111, 1'b0);
        chk("clr_po", po_m, 4'b0111);
        chk("clr_po_lsb", po_l, 4'b1110);
        chk("clr_pv3", pv_m, 1'b1);

        // Asynchronous reset mid-frame
        send_bit(1'b1); send_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_po", po_m, 4'h0);
        chk("arst_pv", pv_m, 1'b0);
        chk("arst_cnt", cnt_m, 3'd0);
        chk("arst_po_lsb", po_l, 4'h0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(4'b1001, 1'b0);
        chk("post_rst_po", po_m, 4'b1001);
        chk("post_rst_pv", pv_m, 1'b1);

`ifdef SIPO_PARITY_CHK_EN
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        chk("par_ok_perr", perr_m, 1'b0);
        chk("par_ok_po", po_m, 4'b1011);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        chk("par_bad_perr", perr_m, 1'b1);
        chk("par_bad_po", po_m, 4'b1011);
        do_clear();
        chk("par_clr_perr", perr_m, 1'b0);
`else
        chk("perr_tied", perr_m, 1'b0);
        chk("perr_tied_lsb", perr_l, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
